mux_nin_1out_rr: RTL
====================

# mux_nin_1out_rr

Registered N-input, one-output data selector with per-channel valid/ready handshakes and a single output pipeline stage. It generalises the team's three-input selector in data width and channel count, and supports two selection modes: fixed (external select) and round-robin (fair arbitration across valid channels). It sits between multiple producers, such as ALU results, memory read data or UART bytes, and a single consumer that can apply backpressure.

## Interface
Parameters:
- DB, 16, data width in bits of each channel and of the output
- NCH, 3, number of input channels (≥2)
- SW, $clog2(NCH), select/channel-index width (localparam, not overridable)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- dato_in  in  NCH*DB  flattened channel data; channel k occupies bits [k*DB +: DB]
- valid_in  in  NCH  channel k presents a valid word
- ready_in  out  NCH  channel k's word is accepted this cycle
- sel  in  SW  channel index used in fixed mode
- modo  in  1  0 = fixed (sel), 1 = round-robin
- salida  out  DB  registered output word
- salida_valid  out  1  salida holds an unconsumed word
- salida_ready  in  1  consumer accepts salida this cycle
- canal_out  out  SW  index of the channel that produced salida

## Operation
- Transfer on channel k occurs when valid_in[k] && ready_in[k]. Output transfer occurs when salida_valid && salida_ready.
- load_en = !salida_valid || salida_ready. The output stage accepts a new word when it is empty or is being drained in the same cycle.
- Grant, fixed mode: grant = sel if sel < NCH and valid_in[sel]; otherwise there is no grant. An out-of-range sel never grants, and the output holds its last value. This replaces the old behaviour of latching on an unused select code.
- Grant, round-robin mode: starting at pointer ptr, the first k with valid_in[k] is chosen, scanning cyclically ptr, ptr+1, …, NCH-1, 0, …, ptr-1. If no channel is valid, there is no grant.
- ready_in[k] = load_en && grant_valid && grant == k. At most one bit is set, and it is combinational from valid_in, sel, modo, ptr and salida_ready.
- On a channel transfer, the output register behaves as follows:
  - salida ← word from the granted channel
  - canal_out ← grant index
  - salida_valid ← 1
- On an output transfer with no new grant, salida_valid ← 0. salida and canal_out keep their values.
- ptr update: on a round-robin transfer, ptr ← (grant+1) mod NCH, wrapping NCH-1 → 0. ptr holds in fixed mode and whenever there is no transfer.
- A change of modo takes effect at the next arbitration. A word already in the output register is not affected.

## Timing
- Reset (asynchronous assert, synchronous release to clk) sets:
  - salida = 0
  - salida_valid = 0
  - canal_out = 0
  - ptr = 0
- While rst_n = 0, ready_in = 0.
- Latency: one cycle from channel transfer to salida_valid = 1.
- Throughput: one word per cycle when salida_ready is held at 1.
- While salida_valid && !salida_ready, salida and canal_out are stable and all ready_in are 0.
- Simultaneous output drain and new grant in the same cycle: the new word is loaded and salida_valid stays 1 with no bubble.
- Reset asserted mid-transfer: the in-flight word is discarded. After release, ptr restarts at 0.

## Structure
- Shared package mux_pkg:
  - MODO_FIJO = 1'b0 and MODO_RR = 1'b1
  - a function packing and unpacking channel k of a flattened bus
- Sub-module rr_arbiter (parameter NCH) contains:
  - the cyclic priority search, implemented as a double-width mask or a rotate
  - the ptr register
  - outputs grant, grant_valid; input advance
- The top level contains the fixed/round-robin grant mux, load_en, the output register and the ready_in decode.

## Test plan
1. Reset, then DB=16, NCH=3, modo=0, sel=2, valid_in=3'b111, channel 2 = 16'hA5A5, salida_ready=1 → ready_in=3'b100. The next cycle, salida=16'hA5A5, canal_out=2, salida_valid=1.
2. Fixed mode, sel=3 (out of range) with all channels valid → ready_in=0 for 10 cycles. salida and salida_valid are unchanged from the previous value.
3. Round-robin, all three channels valid continuously, salida_ready=1 → canal_out sequence 0,1,2,0,1,2 on consecutive cycles, one word per cycle.
4. Round-robin with only channels 0 and 2 valid, ptr=1 → channel 2 is granted first, then 0, then 2. Wrap-around is exercised.
5. Backpressure: salida_valid=1, salida_ready=0 for 5 cycles with channels valid → ready_in=0 and salida is stable. Raising salida_ready loads the next word the same cycle with no bubble.
6. Assert rst_n=0 mid-stream for 1 cycle → salida=0, salida_valid=0 and canal_out=0 immediately (asynchronous). After release, round-robin grants start at channel 0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the N-input registered selector: mode encodings and
// helpers for addressing one channel inside a flattened data bus.
package mux_pkg;

   localparam logic MODO_FIJO = 1'b0;
   localparam logic MODO_RR   = 1'b1;

   // Bit offset of channel k in a flattened bus of db-bit words; used both to
   // pack a word into the bus and to slice it back out.
   function automatic int unsigned chanLsb(input int unsigned k, input int unsigned db);
      return k * db;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: cyclic priority search starting at ptr, plus the ptr
// register that moves past the winner whenever a grant is consumed.
module rr_arbiter #(
   parameter  int unsigned NCH = 3,
   localparam int unsigned SW  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [NCH-1:0] req,
   input  logic           advance,
   output logic [SW-1:0]  grant,
   output logic           grantValid
);

   logic [SW-1:0]    ptrQ, ptrD;
   logic [2*NCH-1:0] reqDbl;
   logic [NCH-1:0]   reqRot;
   int unsigned      idx;

   // Rotate requests so ptr lands on bit 0, then take the lowest set bit.
   always_comb begin
      reqDbl     = {req, req} >> ptrQ;
      reqRot     = reqDbl[NCH-1:0];
      grant      = '0;
      grantValid = 1'b0;
      idx        = 0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (reqRot[i]) begin
            idx = int'(ptrQ) + i;
            if (idx >= NCH) idx = idx - NCH;
            grant      = SW'(idx);
            grantValid = 1'b1;
         end
      end
   end

   always_comb begin
      ptrD = ptrQ;
      if (advance && grantValid) begin
         ptrD = (grant == SW'(NCH - 1)) ? '0 : grant + SW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptrQ <= '0;
      else        ptrQ <= ptrD;
   end

endmodule

// File: rtl/mux_nin_1out_rr.sv
// Registered N-to-1 selector with valid/ready handshakes on every channel and
// on the output; selection is either by external index or round-robin.
module mux_nin_1out_rr
   import mux_pkg::*;
#(
   parameter  int unsigned DB  = 16,
   parameter  int unsigned NCH = 3,
   localparam int unsigned SW  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NCH*DB-1:0] dato_in,
   input  logic [NCH-1:0]    valid_in,
   output logic [NCH-1:0]    ready_in,
   input  logic [SW-1:0]     sel,
   input  logic              modo,
   output logic [DB-1:0]     salida,
   output logic              salida_valid,
   input  logic              salida_ready,
   output logic [SW-1:0]     canal_out
);

   logic [SW-1:0] rrGrant, fixGrant, grant;
   logic          rrValid, fixValid, grantValid;
   logic          loadEn, transfer, advance;
   logic [DB-1:0] grantData;

   rr_arbiter #(
      .NCH(NCH)
   ) uArb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (valid_in),
      .advance   (advance),
      .grant     (rrGrant),
      .grantValid(rrValid)
   );

   // An out-of-range sel matches no channel and therefore never grants.
   always_comb begin
      fixGrant = sel;
      fixValid = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         if (sel == SW'(k) && valid_in[k]) fixValid = 1'b1;
      end
   end

   assign grant      = (modo == MODO_RR) ? rrGrant : fixGrant;
   assign grantValid = (modo == MODO_RR) ? rrValid : fixValid;
   assign loadEn     = !salida_valid || salida_ready;
   assign transfer   = rst_n && loadEn && grantValid;
   assign advance    = transfer && (modo == MODO_RR);

   always_comb begin
      ready_in  = '0;
      grantData = '0;
      for (int k = 0; k < NCH; k++) begin
         if (grant == SW'(k)) begin
            ready_in[k] = transfer;
            grantData   = dato_in[chanLsb(k, DB) +: DB];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         salida       <= '0;
         salida_valid <= 1'b0;
         canal_out    <= '0;
      end else if (transfer) begin
         salida       <= grantData;
         canal_out    <= grant;
         salida_valid <= 1'b1;
      end else if (salida_ready) begin
         salida_valid <= 1'b0;
      end
   end

endmodule
